// File: rtl/alu_pkg.sv
// Shared widths and ALU select codes for the execute front end and the ALU.
package alu_pkg;

  localparam int W  = 32;
  localparam int RW = 5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLT = 4'd2;
  localparam logic [3:0] OP_SGT = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd8;
  localparam logic [3:0] OP_LUI = 4'd9;
  localparam logic [3:0] OP_SLL = 4'd10;
  localparam logic [3:0] OP_SRL = 4'd11;
  localparam logic [3:0] OP_SRA = 4'd12;
  localparam logic [3:0] OP_INC = 4'd13;
  localparam logic [3:0] OP_DEC = 4'd14;
  localparam logic [3:0] OP_HAM = 4'd15;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding mux: picks the youngest in-flight producer of a source
// register, falling back to the register-file value. Index 0 never forwards.
module fwd_sel #(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] idx,
  input  logic [W-1:0]  rf_val,
  input  logic          s1_en,
  input  logic [RW-1:0] s1_rd,
  input  logic [W-1:0]  s1_val,
  input  logic          s2_en,
  input  logic [RW-1:0] s2_rd,
  input  logic [W-1:0]  s2_val,
  output logic [W-1:0]  operand
);

  // S1 holds the younger op, so it is checked before S2.
  always_comb begin
    operand = rf_val;
    if (idx != '0) begin
      if (s1_en && (s1_rd == idx)) begin
        operand = s1_val;
      end else if (s2_en && (s2_rd == idx)) begin
        operand = s2_val;
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage elastic execute front end: S1 registers ALU operands/select,
// S2 captures the ALU result for writeback. Both stages use valid/ready flow.
module alu_issue_stage #(
  parameter int W  = alu_pkg::W,
  parameter int RW = alu_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [RW-1:0] in_rs,
  input  logic [RW-1:0] in_rt,
  input  logic [W-1:0]  in_rs_val,
  input  logic [W-1:0]  in_rt_val,
  input  logic [15:0]   in_imm,
  input  logic          in_use_imm,
  input  logic          in_imm_sext,
  input  logic [RW-1:0] in_rd,
  input  logic          in_wr_en,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_sel,
  input  logic [W-1:0]  alu_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_res,
  output logic [RW-1:0] out_rd,
  output logic          out_wr_en
);
  import alu_pkg::*;

  logic          s1_full;
  logic [RW-1:0] s1_rd;
  logic          s1_wr_en;
  logic          s2_full;
  logic [W-1:0]  s2_res;
  logic [RW-1:0] s2_rd;
  logic          s2_wr_en;

  logic          s2_adv;
  logic          accept;
  logic          s1_tag_en;
  logic          s2_tag_en;
  logic          sext_eff;
  logic [W-1:0]  imm_ext;
  logic [W-1:0]  fwd_a;
  logic [W-1:0]  fwd_b;
  logic [W-1:0]  b_next;

  assign s2_adv   = s1_full & (~s2_full | out_ready);
  assign in_ready = ~s1_full | s2_adv;
  assign accept   = in_valid & in_ready;

  assign s1_tag_en = s1_full & s1_wr_en;
  assign s2_tag_en = s2_full & s2_wr_en;

  // LUI places the raw 16 bits in the upper half, so it never sign-extends.
  assign sext_eff = in_imm_sext & (in_op != OP_LUI);
  assign imm_ext  = {{(W-16){in_imm[15] & sext_eff}}, in_imm};

  fwd_sel #(.W(W), .RW(RW)) u_fwd_a (
    .idx     (in_rs),
    .rf_val  (in_rs_val),
    .s1_en   (s1_tag_en),
    .s1_rd   (s1_rd),
    .s1_val  (alu_res),
    .s2_en   (s2_tag_en),
    .s2_rd   (s2_rd),
    .s2_val  (s2_res),
    .operand (fwd_a)
  );

  fwd_sel #(.W(W), .RW(RW)) u_fwd_b (
    .idx     (in_rt),
    .rf_val  (in_rt_val),
    .s1_en   (s1_tag_en),
    .s1_rd   (s1_rd),
    .s1_val  (alu_res),
    .s2_en   (s2_tag_en),
    .s2_rd   (s2_rd),
    .s2_val  (s2_res),
    .operand (fwd_b)
  );

  assign b_next = in_use_imm ? imm_ext : fwd_b;

  // S1 operand register: loads on accept, empties when its op moves to S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full  <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= OP_ADD;
      s1_rd    <= '0;
      s1_wr_en <= 1'b0;
    end else begin
      if (flush) begin
        s1_full <= 1'b0;
      end else if (accept) begin
        s1_full <= 1'b1;
      end else if (s2_adv) begin
        s1_full <= 1'b0;
      end
      if (accept && !flush) begin
        alu_a    <= fwd_a;
        alu_b    <= b_next;
        alu_sel  <= in_op;
        s1_rd    <= in_rd;
        s1_wr_en <= in_wr_en;
      end
    end
  end

  // S2 result register: captures the ALU output, holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_full  <= 1'b0;
      s2_res   <= '0;
      s2_rd    <= '0;
      s2_wr_en <= 1'b0;
    end else begin
      if (flush) begin
        s2_full <= 1'b0;
      end else if (s2_adv) begin
        s2_full <= 1'b1;
      end else if (out_ready) begin
        s2_full <= 1'b0;
      end
      if (s2_adv && !flush) begin
        s2_res   <= alu_res;
        s2_rd    <= s1_rd;
        s2_wr_en <= s1_wr_en;
      end
    end
  end

  assign out_valid = s2_full;
  assign out_res   = s2_res;
  assign out_rd    = s2_rd;
  assign out_wr_en = s2_wr_en;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [15:0] in_imm;
  logic        in_use_imm;
  logic        in_imm_sext;
  logic [4:0]  in_rd;
  logic        in_wr_en;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic        out_wr_en;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  alu_issue_stage u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_imm_sext(in_imm_sext),
    .in_rd(in_rd), .in_wr_en(in_wr_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_rd(out_rd), .out_wr_en(out_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in combinational ALU.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] sel);
    logic [31:0] r;
    case (sel)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SGT: r = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_NOR: r = ~(a | b);
      OP_LUI: r = b << 16;
      OP_SLL: r = a << b[4:0];
      OP_SRL: r = a >> b[4:0];
      OP_SRA: r = $signed(a) >>> b[4:0];
      OP_INC: r = a + 32'd1;
      OP_DEC: r = a - 32'd1;
      default: r = 32'($countones(a));
    endcase
    return r;
  endfunction

  assign alu_res = alu_f(alu_a, alu_b, alu_sel);

  // ---------------- behavioural model ----------------
  // In-flight ops in program order; the oldest may be sitting in the output slot.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        wr;
    bit          at_out;
  } ent_t;

  ent_t q[$];
  ent_t m_new;
  ent_t m_head;
  bit   m_fire;
  bit   m_deq;

  // Value a source register should read: youngest in-flight writer wins.
  function automatic logic [31:0] src_val(input logic [4:0] s, input logic [31:0] rf);
    if (s == 5'd0) return rf;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].wr && q[i].rd == s) return q[i].res;
    end
    return rf;
  endfunction

  function automatic logic [31:0] imm_val(input logic [15:0] imm, input logic sext,
                                          input logic [3:0] op);
    if (sext && op != OP_LUI && imm[15]) return {16'hFFFF, imm};
    return {16'h0000, imm};
  endfunction

  // Model update on each edge; reset drops everything.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_fire = in_valid && (q.size() < 2 || out_ready);
      m_deq  = (q.size() > 0) && q[0].at_out && out_ready;
      if (m_fire) begin
        m_new.a      = src_val(in_rs, in_rs_val);
        m_new.b      = in_use_imm ? imm_val(in_imm, in_imm_sext, in_op) : src_val(in_rt, in_rt_val);
        m_new.sel    = in_op;
        m_new.rd     = in_rd;
        m_new.wr     = in_wr_en;
        m_new.res    = alu_f(m_new.a, m_new.b, in_op);
        m_new.at_out = 1'b0;
      end
      if (flush) begin
        q.delete();
      end else begin
        if (m_deq) void'(q.pop_front());
        if (q.size() > 0 && !q[0].at_out) begin
          m_head = q[0];
          m_head.at_out = 1'b1;
          q[0] = m_head;
        end
        if (m_fire) q.push_back(m_new);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("m_in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
      chk("m_out_valid", 32'(out_valid), 32'((q.size() > 0) && q[0].at_out));
      if (q.size() > 0 && q[0].at_out) begin
        chk("m_out_res", out_res, q[0].res);
        chk("m_out_rd", 32'(out_rd), 32'(q[0].rd));
        chk("m_out_wr_en", 32'(out_wr_en), 32'(q[0].wr));
      end
      if (q.size() > 0 && !q[q.size()-1].at_out) begin
        chk("m_alu_a", alu_a, q[q.size()-1].a);
        chk("m_alu_b", alu_b, q[q.size()-1].b);
        chk("m_alu_sel", 32'(alu_sel), 32'(q[q.size()-1].sel));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] rsv,
                        input logic [4:0] rt, input logic [31:0] rtv, input logic use_imm,
                        input logic sext, input logic [15:0] imm, input logic [4:0] rd,
                        input logic wr);
    in_op = op; in_rs = rs; in_rs_val = rsv; in_rt = rt; in_rt_val = rtv;
    in_use_imm = use_imm; in_imm_sext = sext; in_imm = imm; in_rd = rd; in_wr_en = wr;
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_rs = '0; in_rt = '0; in_rs_val = '0; in_rt_val = '0;
    in_imm = '0; in_use_imm = 1'b0; in_imm_sext = 1'b0; in_rd = '0; in_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_wr_en", 32'(out_wr_en), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_out_res", out_res, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk_en = 1'b1;
    $display("txn: reset state checked");

    // single ADD
    set_op(OP_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 1'b0, 16'd0, 5'd3, 1'b1);
    tick; in_valid = 1'b0;
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    chk("add_alu_sel", 32'(alu_sel), 32'd0);
    tick;
    chk("add_out_valid", 32'(out_valid), 32'd1);
    chk("add_out_res", out_res, 32'd12);
    chk("add_out_rd", 32'(out_rd), 32'd3);
    $display("txn: ADD 5+7 -> r3");

    // immediate extension
    set_op(OP_ADD, 5'd1, 32'd1, 5'd0, 32'd0, 1'b1, 1'b1, 16'hFFFF, 5'd5, 1'b1);
    tick; in_valid = 1'b0;
    chk("imm_sext_b", alu_b, 32'hFFFFFFFF);
    tick;
    chk("imm_sext_res", out_res, 32'd0);
    set_op(OP_ADD, 5'd1, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0, 16'hFFFF, 5'd6, 1'b1);
    tick; in_valid = 1'b0;
    chk("imm_zext_b", alu_b, 32'h0000FFFF);
    set_op(OP_LUI, 5'd1, 32'd1, 5'd0, 32'd0, 1'b1, 1'b1, 16'hFFFF, 5'd7, 1'b1);
    tick; in_valid = 1'b0;
    chk("imm_lui_b", alu_b, 32'h0000FFFF);
    tick; tick;
    $display("txn: immediate extension");

    // back-to-back dependency through S1 then S2
    set_op(OP_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 1'b0, 16'd0, 5'd3, 1'b1);
    tick;
    set_op(OP_SUB, 5'd3, 32'd0, 5'd2, 32'd2, 1'b0, 1'b0, 16'd0, 5'd4, 1'b1);
    tick;
    chk("dep_s1_alu_a", alu_a, 32'd12);
    chk("dep_s1_alu_b", alu_b, 32'd2);
    set_op(OP_ADD, 5'd3, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 16'd0, 5'd6, 1'b1);
    tick; in_valid = 1'b0;
    chk("dep_s2_alu_a", alu_a, 32'd12);
    chk("dep_sub_res", out_res, 32'd10);
    chk("dep_sub_rd", 32'(out_rd), 32'd4);
    tick; tick;
    $display("txn: forwarding chain");

    // r0 never forwards
    set_op(OP_ADD, 5'd1, 32'd99, 5'd2, 32'd0, 1'b0, 1'b0, 16'd0, 5'd0, 1'b1);
    tick;
    set_op(OP_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 16'd0, 5'd7, 1'b1);
    tick; in_valid = 1'b0;
    chk("r0_alu_a", alu_a, 32'd0);
    tick; tick;
    $display("txn: r0 guard");

    // backpressure: two fit, third waits
    out_ready = 1'b0;
    set_op(OP_ADD, 5'd1, 32'd10, 5'd2, 32'd1, 1'b0, 1'b0, 16'd0, 5'd8, 1'b1);
    tick;
    set_op(OP_ADD, 5'd1, 32'd20, 5'd2, 32'd2, 1'b0, 1'b0, 16'd0, 5'd9, 1'b1);
    tick;
    set_op(OP_ADD, 5'd1, 32'd30, 5'd2, 32'd3, 1'b0, 1'b0, 16'd0, 5'd10, 1'b1);
    #1;
    chk("bp_in_ready_lo", 32'(in_ready), 32'd0);
    chk("bp_hold_res", out_res, 32'd11);
    tick;
    chk("bp_in_ready_lo2", 32'(in_ready), 32'd0);
    chk("bp_hold_res2", out_res, 32'd11);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_hi", 32'(in_ready), 32'd1);
    tick; in_valid = 1'b0;
    chk("bp_drain2_res", out_res, 32'd22);
    chk("bp_drain2_rd", 32'(out_rd), 32'd9);
    tick;
    chk("bp_drain3_res", out_res, 32'd33);
    chk("bp_drain3_rd", 32'(out_rd), 32'd10);
    tick;
    chk("bp_empty", 32'(out_valid), 32'd0);
    $display("txn: backpressure drain");

    // flush with both stages full and a simultaneous accept
    out_ready = 1'b0;
    set_op(OP_ADD, 5'd1, 32'd1, 5'd2, 32'd1, 1'b0, 1'b0, 16'd0, 5'd11, 1'b1);
    tick;
    set_op(OP_ADD, 5'd1, 32'd2, 5'd2, 32'd2, 1'b0, 1'b0, 16'd0, 5'd12, 1'b1);
    tick;
    out_ready = 1'b1; flush = 1'b1;
    set_op(OP_ADD, 5'd1, 32'd3, 5'd2, 32'd3, 1'b0, 1'b0, 16'd0, 5'd13, 1'b1);
    tick; flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    tick;
    chk("fl_out_valid2", 32'(out_valid), 32'd0);
    tick;
    chk("fl_out_valid3", 32'(out_valid), 32'd0);
    $display("txn: flush");

    // randomized traffic, checked by the model each cycle
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        tick;
        rst_n = 1'b1;
        $display("txn: mid-run reset");
      end
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 39) == 0);
      in_op       = 4'($urandom_range(0, 15));
      in_rs       = 5'($urandom_range(0, 3));
      in_rt       = 5'($urandom_range(0, 3));
      in_rs_val   = $urandom;
      in_rt_val   = $urandom;
      in_imm      = 16'($urandom);
      in_use_imm  = 1'($urandom_range(0, 1));
      in_imm_sext = 1'($urandom_range(0, 1));
      in_rd       = 5'($urandom_range(0, 3));
      in_wr_en    = 1'($urandom_range(0, 1));
      tick;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick; tick; tick;
    $display("txn: random traffic done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
